multdiv: RTL and testbench

MULTDIV -- requirements
Module: multdiv

---
 rtl/multdiv.sv | 196 +++++++++++++++++++
 tb/tb_multdiv.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv.sv
// rtl/multdiv.sv - iterative signed 32x32 multiply / 32/32 divide unit
//
// Ports:
//   clock          - sole clock, rising edge
//   reset          - synchronous active-high reset
//   ctrl_MULT      - start signed multiply (sampled in IDLE only, wins over ctrl_DIV)
//   ctrl_DIV       - start signed divide (sampled in IDLE only)
//   data_operandA  - multiplicand / dividend
//   data_operandB  - multiplier / divisor
//   data_result    - low 32 bits of product, or quotient; held until next completion
//   data_exception - multiply overflow or divide error; held with data_result
//   data_resultRDY - one-cycle completion pulse (high only in DONE)
//   busy           - high while an operation iterates (MULT/DIV)

module multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  cnt;

    // Multiply datapath: sign-extended multiplicand shifted left each step,
    // multiplier shifted right so bit 0 is always the current partial product.
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;

    // Divide datapath: restoring division on magnitudes.
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic        div_neg;
    logic        div_ovf;

    // ---------------------------------------------------------------
    // Multiply step. The multiplier's bit 31 carries weight -2^31 in
    // two's complement, so the final step subtracts instead of adding.
    // ---------------------------------------------------------------
    logic [63:0] mult_addend;
    logic [63:0] acc_next;
    logic        mult_ovf;

    always_comb begin
        mult_addend = mplier[0] ? mcand : 64'd0;
        if (cnt == 5'd31) begin
            acc_next = acc - mult_addend;
        end else begin
            acc_next = acc + mult_addend;
        end
        // Fits in 32-bit signed iff bits [63:31] are all copies of the sign.
        mult_ovf = !((acc_next[63:31] == 33'd0) || (acc_next[63:31] == {33{1'b1}}));
    end

    // ---------------------------------------------------------------
    // Divide step: shift the next dividend bit into the partial
    // remainder and keep the trial subtraction when it does not borrow.
    // ---------------------------------------------------------------
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic        ge;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_signed;

    always_comb begin
        rem_sh     = {rem[31:0], quo[31]};
        diff       = {1'b0, rem_sh} - {2'b00, dvsr};
        ge         = !diff[33];
        rem_next   = ge ? diff[32:0] : rem_sh;
        quo_next   = {quo[30:0], ge};
        quo_signed = div_neg ? (32'd0 - quo_next) : quo_next;
    end

    // Magnitudes of the incoming operands; 0x80000000 maps onto itself,
    // which is the correct unsigned magnitude 2^31.
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    always_comb begin
        mag_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
        mag_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
    end

    // ---------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 5'd0;
            acc            <= 64'd0;
            mcand          <= 64'd0;
            mplier         <= 32'd0;
            rem            <= 33'd0;
            quo            <= 32'd0;
            dvsr           <= 32'd0;
            div_neg        <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_resultRDY <= 1'b0;
                    if (ctrl_MULT) begin
                        acc    <= 64'd0;
                        mcand  <= {{32{data_operandA[31]}}, data_operandA};
                        mplier <= data_operandB;
                        cnt    <= 5'd0;
                        busy   <= 1'b1;
                        state  <= MULT;
                    end else if (ctrl_DIV) begin
                        cnt <= 5'd0;
                        if (data_operandB == 32'd0) begin
                            // Divide by zero completes immediately.
                            data_result    <= 32'd0;
                            data_exception <= 1'b1;
                            data_resultRDY <= 1'b1;
                            busy           <= 1'b0;
                            state          <= DONE;
                        end else begin
                            rem     <= 33'd0;
                            quo     <= mag_a;
                            dvsr    <= mag_b;
                            div_neg <= data_operandA[31] ^ data_operandB[31];
                            div_ovf <= (data_operandA == 32'h8000_0000) &&
                                       (data_operandB == 32'hFFFF_FFFF);
                            busy    <= 1'b1;
                            state   <= DIV;
                        end
                    end
                end

                MULT: begin
                    acc    <= acc_next;
                    mcand  <= {mcand[62:0], 1'b0};
                    mplier <= {1'b0, mplier[31:1]};
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        data_result    <= acc_next[31:0];
                        data_exception <= mult_ovf;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end
                end

                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        // -2^31 / -1 yields magnitude 2^31 with positive sign,
                        // which wraps to 0x80000000 and is flagged.
                        data_result    <= quo_signed;
                        data_exception <= div_ovf;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end
                end

                DONE: begin
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end

                default: begin
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv.sv
// tb/tb_multdiv.sv - directed self-checking bench for multdiv

module tb_multdiv;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int vectors;
    int miscompares;

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Start an operation and wait (bounded) for completion.
    // lat counts edges with the start-sampling edge as edge 1.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output logic [31:0] res,
                          output logic exc, output logic rdy_after, output logic [31:0] res_after);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        busy_cnt  = 0;
        while (!data_resultRDY && lat < 60) begin
            if (busy) busy_cnt++;
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
        res = data_result;
        exc = data_exception;
        @(posedge clock);
        @(negedge clock);
        rdy_after = data_resultRDY;
        res_after = data_result;
    endtask

    int          lat;
    int          bcnt;
    int          pulses;
    logic [31:0] res;
    logic        exc;
    logic        rdy_after;
    logic [31:0] res_after;
    logic [31:0] cap;

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_rdy", {63'd0, data_resultRDY}, 64'd0);
        check("reset_result", {32'd0, data_result}, 64'd0);
        check("reset_exc", {63'd0, data_exception}, 64'd0);
        reset = 1'b0;

        // 7 * -6 = -42
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, lat, bcnt, res, exc, rdy_after, res_after);
        check("mul_7x-6_lat", 64'(lat), 64'd33);
        check("mul_7x-6_busy", 64'(bcnt), 64'd32);
        check("mul_7x-6_res", {32'd0, res}, 64'h0000_0000_FFFF_FFD6);
        check("mul_7x-6_exc", {63'd0, exc}, 64'd0);
        check("mul_7x-6_rdy_pulse", {63'd0, rdy_after}, 64'd0);
        check("mul_7x-6_hold", {32'd0, res_after}, 64'h0000_0000_FFFF_FFD6);

        // 2^16 * 2^16 overflows
        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, lat, bcnt, res, exc, rdy_after, res_after);
        check("mul_2^32_res", {32'd0, res}, 64'd0);
        check("mul_2^32_exc", {63'd0, exc}, 64'd1);

        // max positive * 1
        run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, lat, bcnt, res, exc, rdy_after, res_after);
        check("mul_max_res", {32'd0, res}, 64'h0000_0000_7FFF_FFFF);
        check("mul_max_exc", {63'd0, exc}, 64'd0);

        // -2^31 * 1 fits, -2^31 * -1 does not
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, lat, bcnt, res, exc, rdy_after, res_after);
        check("mul_min_x1_res", {32'd0, res}, 64'h0000_0000_8000_0000);
        check("mul_min_x1_exc", {63'd0, exc}, 64'd0);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, res, exc, rdy_after, res_after);
        check("mul_min_x-1_res", {32'd0, res}, 64'h0000_0000_8000_0000);
        check("mul_min_x-1_exc", {63'd0, exc}, 64'd1);

        // -7 / 2 = -3
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt, res, exc, rdy_after, res_after);
        check("div_-7/2_lat", 64'(lat), 64'd33);
        check("div_-7/2_res", {32'd0, res}, 64'h0000_0000_FFFF_FFFD);
        check("div_-7/2_exc", {63'd0, exc}, 64'd0);

        // -100 / -7 = 14 ; 7 / -2 = -3 ; 0 / 5 = 0
        run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, bcnt, res, exc, rdy_after, res_after);
        check("div_-100/-7_res", {32'd0, res}, 64'd14);
        run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt, res, exc, rdy_after, res_after);
        check("div_7/-2_res", {32'd0, res}, 64'h0000_0000_FFFF_FFFD);
        run_op(1'b0, 1'b1, 32'd0, 32'd5, lat, bcnt, res, exc, rdy_after, res_after);
        check("div_0/5_res", {32'd0, res}, 64'd0);
        check("div_0/5_exc", {63'd0, exc}, 64'd0);

        // 100 / 0: immediate completion
        run_op(1'b0, 1'b1, 32'd100, 32'd0, lat, bcnt, res, exc, rdy_after, res_after);
        check("div0_lat", 64'(lat), 64'd1);
        check("div0_res", {32'd0, res}, 64'd0);
        check("div0_exc", {63'd0, exc}, 64'd1);
        check("div0_rdy_pulse", {63'd0, rdy_after}, 64'd0);

        // both starts high: multiply wins
        run_op(1'b1, 1'b1, 32'd9, 32'd3, lat, bcnt, res, exc, rdy_after, res_after);
        check("both_lat", 64'(lat), 64'd33);
        check("both_res", {32'd0, res}, 64'd27);
        check("both_exc", {63'd0, exc}, 64'd0);

        // ctrl_DIV pulsed mid-multiply with new operands: ignored
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'hFFFF_FFFD;
        data_operandB = 32'd5;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (4) @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd1;
        data_operandB = 32'd0;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        pulses = 0;
        cap    = 32'd0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                pulses++;
                cap = data_result;
            end
        end
        check("middiv_pulses", 64'(pulses), 64'd1);
        check("middiv_res", {32'd0, cap}, 64'h0000_0000_FFFF_FFF1);

        // reset at cycle 10 of a multiply, with ctrl_MULT also high
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd3;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (9) @(negedge clock);
        reset     = 1'b1;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rdy", {63'd0, data_resultRDY}, 64'd0);
        check("rst_result", {32'd0, data_result}, 64'd0);
        check("rst_exc", {63'd0, data_exception}, 64'd0);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;

        // -2^31 / -1 immediately after reset
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, res, exc, rdy_after, res_after);
        check("divovf_lat", 64'(lat), 64'd33);
        check("divovf_res", {32'd0, res}, 64'h0000_0000_8000_0000);
        check("divovf_exc", {63'd0, exc}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
